// File: rtl/reset_requester.sv
// reset_requester: builds the active-low board reset request.
// There are three request sources: the debounced front-panel button,
// watchdog expiry and a software strobe. Each request is stretched to a
// fixed length and followed by a holdoff. The holdoff lasts until the
// button is released. The source of the last request is kept on `cause`.
module reset_requester #(
  parameter int DEB_BITS     = 16,
  parameter int WDT_BITS     = 20,
  parameter int REQ_LEN_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       sw_rst,
  output logic       rst_req_n,
  output logic [1:0] cause,
  output logic       busy
);

  localparam int LEN_W = REQ_LEN_BITS + 1;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                stable_q, stable_d;
  logic [DEB_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic [WDT_BITS-1:0] wdt_cnt_q, wdt_cnt_d;
  logic [LEN_W-1:0]    len_cnt_q, len_cnt_d;
  logic                rst_req_n_q, rst_req_n_d;
  logic [1:0]          cause_q, cause_d;
  logic                busy_q, busy_d;

  logic                btn_evt;
  logic                wdt_evt;
  logic                sw_evt;
  logic                any_evt;
  logic [1:0]          req_cause;
  logic                len_done;

  // The length counter's MSB means the current phase has run its full length.
  assign len_done = len_cnt_q[REQ_LEN_BITS];

  // The synchronizer and the stable button value come out of reset as
  // "released". A button held down through reset therefore needs a fresh
  // debounce before it can count as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      stable_q    <= 1'b1;
      deb_cnt_q   <= '0;
      wdt_cnt_q   <= '0;
      len_cnt_q   <= '0;
      rst_req_n_q <= 1'b1;
      cause_q     <= CAUSE_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      len_cnt_q   <= len_cnt_d;
      rst_req_n_q <= rst_req_n_d;
      cause_q     <= cause_d;
      busy_q      <= busy_d;
    end
  end

  // The button goes through a 2-FF synchronizer. The stable value then
  // follows it only after an unbroken run of differing cycles.
  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (&deb_cnt_q) begin
        stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_BITS'(1);
      end
    end
  end

  // A press is the cycle in which the stable value falls. The event is used
  // on the same edge that updates stable_q.
  assign btn_evt = stable_q & ~stable_d;

  // The watchdog counts only while it is enabled and idle. A kick wins over
  // the increment. Reaching all-ones without a kick fires the watchdog.
  always_comb begin
    wdt_cnt_d = '0;
    wdt_evt   = 1'b0;
    if (wdt_en && (state_q == ST_IDLE) && !wdt_kick) begin
      if (&wdt_cnt_q) begin
        wdt_evt = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_BITS'(1);
      end
    end
  end

  // The software strobe counts only in IDLE. All events combine here with
  // fixed priority.
  always_comb begin
    sw_evt    = sw_rst && (state_q == ST_IDLE);
    any_evt   = btn_evt | wdt_evt | sw_evt;
    req_cause = CAUSE_NONE;
    if (btn_evt) begin
      req_cause = CAUSE_BTN;
    end else if (wdt_evt) begin
      req_cause = CAUSE_WDT;
    end else if (sw_evt) begin
      req_cause = CAUSE_SW;
    end
  end

  // Next-state logic. The length counter starts at 1 so that its MSB is set
  // after exactly 2^REQ_LEN_BITS cycles in each phase. After that it holds
  // rather than wraps.
  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_evt) begin
          state_d   = ST_ASSERT;
          len_cnt_d = LEN_W'(1);
        end
      end
      ST_ASSERT: begin
        if (len_done) begin
          state_d   = ST_HOLDOFF;
          len_cnt_d = LEN_W'(1);
        end else begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (len_done && stable_q) begin
          state_d   = ST_IDLE;
          len_cnt_d = '0;
        end else if (!len_done) begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        len_cnt_d = '0;
      end
    endcase
  end

  // Registered outputs are computed from the next state. The request
  // therefore drops on the same edge that accepts the event.
  always_comb begin
    rst_req_n_d = (state_d != ST_ASSERT);
    busy_d      = (state_d != ST_IDLE);
    cause_d     = cause_q;
    if ((state_q == ST_IDLE) && any_evt) begin
      cause_d = req_cause;
    end
  end

  assign rst_req_n = rst_req_n_q;
  assign cause     = cause_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reset_requester.sv
// tb_reset_requester: directed bench for reset_requester built with small
// parameters. Every expected value below is worked out by hand from the
// intended behaviour.
module tb_reset_requester;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       wdt_en;
  logic       wdt_kick;
  logic       sw_rst;
  logic       rst_req_n;
  logic [1:0] cause;
  logic       busy;

  int checkCount;
  int errorCount;
  int reqCount;
  logic prevReqN;

  reset_requester #(
    .DEB_BITS    (3),
    .WDT_BITS    (4),
    .REQ_LEN_BITS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .sw_rst   (sw_rst),
    .rst_req_n(rst_req_n),
    .cause    (cause),
    .busy     (busy)
  );

  // free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // advance one clock edge, sample just after it, and count falling request edges
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (prevReqN && !rst_req_n) reqCount++;
      prevReqN = rst_req_n;
    end
  endtask

  // wait, with a cycle bound, for the block to return to idle
  task automatic waitIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (busy && n < maxCycles) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  // main directed sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    reqCount   = 0;
    prevReqN   = 1'b1;
    rst      = 1'b1;
    btn_n    = 1'b0;
    wdt_en   = 1'b0;
    wdt_kick = 1'b0;
    sw_rst   = 1'b0;

    // 1: reset state; a button held during reset must not request
    applyStimulus(2);
    checkOutput("rst_req_n_after_rst", 32'(rst_req_n), 32'd1);
    checkOutput("cause_after_rst", 32'(cause), 32'd0);
    checkOutput("busy_after_rst", 32'(busy), 32'd0);
    btn_n = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    reqCount = 0;
    applyStimulus(12);
    checkOutput("no_req_after_rst", 32'(reqCount), 32'd0);

    // 2: software strobe, 4-cycle request, 4-cycle holdoff
    sw_rst = 1'b1;
    applyStimulus(1);
    sw_rst = 1'b0;
    checkOutput("sw_req_low_first", 32'(rst_req_n), 32'd0);
    checkOutput("sw_cause", 32'(cause), 32'd3);
    checkOutput("sw_busy", 32'(busy), 32'd1);
    applyStimulus(3);
    checkOutput("sw_req_low_last", 32'(rst_req_n), 32'd0);
    applyStimulus(1);
    checkOutput("sw_req_high_after4", 32'(rst_req_n), 32'd1);
    checkOutput("sw_busy_holdoff", 32'(busy), 32'd1);
    sw_rst = 1'b1;
    applyStimulus(1);
    sw_rst = 1'b0;
    checkOutput("sw_ignored_in_holdoff", 32'(rst_req_n), 32'd1);
    applyStimulus(2);
    checkOutput("sw_busy_end_holdoff", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("sw_busy_low", 32'(busy), 32'd0);
    checkOutput("sw_cause_persists", 32'(cause), 32'd3);
    applyStimulus(6);
    checkOutput("sw_single_request", 32'(reqCount), 32'd1);

    // 3: bouncing button gives nothing; a held press gives exactly one request
    reqCount = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_n = ~btn_n;
      applyStimulus(1);
    end
    checkOutput("bounce_no_req", 32'(reqCount), 32'd0);
    btn_n = 1'b0;
    applyStimulus(12);
    checkOutput("btn_req_count", 32'(reqCount), 32'd1);
    checkOutput("btn_cause", 32'(cause), 32'd1);
    applyStimulus(40);
    checkOutput("btn_held_one_req", 32'(reqCount), 32'd1);
    checkOutput("btn_held_busy", 32'(busy), 32'd1);
    btn_n = 1'b1;
    applyStimulus(9);
    checkOutput("btn_release_debouncing", 32'(busy), 32'd1);
    waitIdle("btn_release_idle", 20);

    // 4: watchdog timeout, then a regularly kicked watchdog
    reqCount = 0;
    wdt_en = 1'b1;
    applyStimulus(15);
    checkOutput("wdt_before_timeout", 32'(rst_req_n), 32'd1);
    applyStimulus(1);
    checkOutput("wdt_timeout_req", 32'(rst_req_n), 32'd0);
    checkOutput("wdt_cause", 32'(cause), 32'd2);
    wdt_en = 1'b0;
    waitIdle("wdt_idle", 20);
    reqCount = 0;
    wdt_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 10 == 9);
      applyStimulus(1);
    end
    wdt_kick = 1'b0;
    wdt_en   = 1'b0;
    checkOutput("wdt_kicked_no_req", 32'(reqCount), 32'd0);

    // 5: button press and watchdog expiry land on the same edge
    reqCount = 0;
    wdt_en = 1'b1;
    applyStimulus(6);
    btn_n = 1'b0;
    applyStimulus(9);
    checkOutput("coinc_before", 32'(rst_req_n), 32'd1);
    applyStimulus(1);
    wdt_en = 1'b0;
    checkOutput("coinc_req_low", 32'(rst_req_n), 32'd0);
    checkOutput("coinc_cause_btn", 32'(cause), 32'd1);
    applyStimulus(3);
    checkOutput("coinc_still_low", 32'(rst_req_n), 32'd0);
    applyStimulus(1);
    checkOutput("coinc_len4", 32'(rst_req_n), 32'd1);
    checkOutput("coinc_single", 32'(reqCount), 32'd1);
    btn_n = 1'b1;
    waitIdle("coinc_idle", 30);

    // 6: rst in the second ASSERT cycle aborts the request
    sw_rst = 1'b1;
    applyStimulus(1);
    sw_rst = 1'b0;
    applyStimulus(1);
    checkOutput("abort_in_assert", 32'(rst_req_n), 32'd0);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("abort_req_high", 32'(rst_req_n), 32'd1);
    checkOutput("abort_busy_low", 32'(busy), 32'd0);
    checkOutput("abort_cause_none", 32'(cause), 32'd0);
    applyStimulus(3);
    checkOutput("abort_stays_high", 32'(rst_req_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
